// File: rtl/vip_pattern_generator.sv
// Video test-pattern source: emits CH x BPC pixels for a programmed number of
// WxH frames into a FIFO write bus, with sof/eol sideband and LFSR throttling.
module vip_pattern_generator #(
    parameter int unsigned CH        = 3,
    parameter int unsigned BPC       = 8,
    parameter int unsigned DIM_W     = 11,
    parameter int unsigned FRAME_W   = 11,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic                abort,
    input  logic [DIM_W-1:0]    cfg_width,
    input  logic [DIM_W-1:0]    cfg_height,
    input  logic [FRAME_W-1:0]  cfg_num_frame,
    input  logic [2:0]          cfg_mode,
    input  logic [CH*BPC-1:0]   cfg_solid,
    input  logic [3:0]          cfg_throttle,
    input  logic                fifo_full,
    output logic [CH*BPC-1:0]   fifo_data,
    output logic                fifo_wrreq,
    output logic                fifo_sof,
    output logic                fifo_eol,
    output logic                busy,
    output logic                done
);

    localparam int unsigned PIX_W = CH * BPC;
    localparam int unsigned IDX_W = 2 * DIM_W;
    localparam int unsigned NREP  = PIX_W / 16 + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               state;
    logic [15:0]          lfsr_q;
    logic [DIM_W-1:0]     x_q;
    logic [DIM_W-1:0]     y_q;
    logic [FRAME_W-1:0]   frame_q;

    // Configuration captured at start; inputs are ignored afterwards
    logic [DIM_W-1:0]     w_q;
    logic [DIM_W-1:0]     h_q;
    logic [FRAME_W-1:0]   nf_q;
    logic [2:0]           mode_q;
    logic [PIX_W-1:0]     solid_q;
    logic [3:0]           thr_q;

    logic                 gate_c;
    logic                 issue_c;
    logic                 x_last_c;
    logic                 y_last_c;
    logic                 frame_last_c;
    logic [2:0]           bar_idx_c;
    logic [PIX_W-1:0]     pixel_c;

    // Free-running Fibonacci LFSR (taps 16,14,13,11), shifts every cycle
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end
    end

    // Issue qualification, raster position flags and current pixel value
    always_comb begin
        gate_c       = (thr_q == 4'd0) || (lfsr_q[3:0] >= thr_q);
        issue_c      = !fifo_full && gate_c;
        x_last_c     = (x_q == w_q - DIM_W'(1));
        y_last_c     = (y_q == h_q - DIM_W'(1));
        frame_last_c = (nf_q != '0) &&
                       ((FRAME_W+1)'(frame_q) + (FRAME_W+1)'(1) == (FRAME_W+1)'(nf_q));
        bar_idx_c    = x_q[7:5];
        pixel_c      = '0;
        case (mode_q)
            3'd1: begin
                for (int unsigned c = 0; c < CH; c++) begin
                    pixel_c[(CH-1-c)*BPC +: BPC] = BPC'(x_q);
                end
            end
            3'd2: begin
                for (int unsigned c = 0; c < CH; c++) begin
                    pixel_c[(CH-1-c)*BPC +: BPC] = BPC'(y_q);
                end
            end
            3'd3: pixel_c = (x_q[3] ^ y_q[3]) ? {PIX_W{1'b1}} : '0;
            3'd4: begin
                for (int unsigned c = 0; c < CH; c++) begin
                    if (c == 0) begin
                        pixel_c[(CH-1-c)*BPC +: BPC] = {BPC{~bar_idx_c[1]}};
                    end else if (c == 1) begin
                        pixel_c[(CH-1-c)*BPC +: BPC] = {BPC{~bar_idx_c[2]}};
                    end else if (c == 2) begin
                        pixel_c[(CH-1-c)*BPC +: BPC] = {BPC{~bar_idx_c[0]}};
                    end else begin
                        pixel_c[(CH-1-c)*BPC +: BPC] = '0;
                    end
                end
            end
            3'd5: pixel_c = PIX_W'(IDX_W'(y_q) * IDX_W'(w_q) + IDX_W'(x_q));
            3'd6: pixel_c = PIX_W'({NREP{lfsr_q}});
            default: pixel_c = solid_q;
        endcase
    end

    // Control FSM, raster counters and registered FIFO write bus
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            x_q        <= '0;
            y_q        <= '0;
            frame_q    <= '0;
            w_q        <= '0;
            h_q        <= '0;
            nf_q       <= '0;
            mode_q     <= '0;
            solid_q    <= '0;
            thr_q      <= '0;
            fifo_data  <= '0;
            fifo_wrreq <= 1'b0;
            fifo_sof   <= 1'b0;
            fifo_eol   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            fifo_wrreq <= 1'b0;
            done       <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        w_q     <= cfg_width;
                        h_q     <= cfg_height;
                        nf_q    <= cfg_num_frame;
                        mode_q  <= cfg_mode;
                        solid_q <= cfg_solid;
                        thr_q   <= cfg_throttle;
                        x_q     <= '0;
                        y_q     <= '0;
                        frame_q <= '0;
                        busy    <= 1'b1;
                        if (cfg_width == '0 || cfg_height == '0) begin
                            state <= S_DONE;
                        end else begin
                            state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else if (issue_c) begin
                        fifo_wrreq <= 1'b1;
                        fifo_data  <= pixel_c;
                        fifo_sof   <= (x_q == '0) && (y_q == '0);
                        fifo_eol   <= x_last_c;
                        if (x_last_c) begin
                            x_q <= '0;
                            if (y_last_c) begin
                                y_q     <= '0;
                                frame_q <= frame_q + FRAME_W'(1);
                                if (frame_last_c) begin
                                    state <= S_DONE;
                                end
                            end else begin
                                y_q <= y_q + DIM_W'(1);
                            end
                        end else begin
                            x_q <= x_q + DIM_W'(1);
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= !abort;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/vip_pattern_generator.md
Name: vip_pattern_generator

Overview:
Synthesizable, parametrised video test-pattern source for the VIP core.
- Generates CH-channel, BPC-bit pixels for a programmable number of WxH frames in one of eight pattern modes.
- Writes into the input FIFO of the processing pipeline over the existing fifo_full / fifo_data / fifo_wrreq write bus, adding start-of-frame and end-of-line sideband bits.
- An optional deterministic LFSR throttle produces bursty traffic for stress tests.

Parameters:
CH, 3, colour channels per pixel; channel 0 is the most-significant field of fifo_data
BPC, 8, bits per channel
DIM_W, 11, width of the dimension and coordinate counters
FRAME_W, 11, width of the frame counter
LFSR_SEED, 16'hACE1, non-zero reset value of the 16-bit LFSR

Ports:
clock  in  1  single clock; all logic rising-edge
reset  in  1  asynchronous, active-high; clears all state
start  in  1  one-cycle pulse; sampled only in IDLE
abort  in  1  synchronous stop; returns to IDLE with no done pulse
cfg_width  in  DIM_W  pixels per line
cfg_height  in  DIM_W  lines per frame
cfg_num_frame  in  FRAME_W  frames to emit; 0 = continuous
cfg_mode  in  3  pattern select (see Behaviour)
cfg_solid  in  CH*BPC  colour for mode 0
cfg_throttle  in  4  0 = full rate; otherwise LFSR gating
fifo_full  in  1  downstream FIFO full; must be an almost-full with at least one free slot of margin
fifo_data  out  CH*BPC  pixel
fifo_wrreq  out  1  write strobe; data valid when high
fifo_sof  out  1  high with the first pixel of each frame
fifo_eol  out  1  high with the last pixel of each line
busy  out  1  high outside IDLE
done  out  1  one-cycle pulse after the last frame

Behaviour:
- Reset: state=IDLE. fifo_data, fifo_wrreq, fifo_sof, fifo_eol, busy and done all 0. x, y and frame counters 0. lfsr=LFSR_SEED.
- States and transitions:
  - IDLE: on start, latch all cfg_* inputs. If the latched width or height is 0, go to DONE; otherwise go to RUN. cfg_* changes after the latch are ignored until the next start.
  - RUN: emit pixels. After the last pixel of the last frame, go to DONE.
  - DONE: assert done for one cycle, then return to IDLE.
  - abort: in RUN or DONE, go to IDLE at the next edge. Any beat already registered still appears; no further beats follow.
  - abort and start together in IDLE: start wins.
- Issue rule: at an edge in RUN with fifo_full==0 and gate==1, the current pixel is issued.
  - The next cycle shows fifo_wrreq=1 together with its fifo_data, fifo_sof and fifo_eol.
  - Any other edge leaves fifo_wrreq=0 and holds fifo_data.
  - The full-to-wrreq path is registered with one cycle of lag, so no pixel is dropped or duplicated under backpressure.
- Latency: start at edge k, first beat visible after edge k+1 when ungated.
- Gate: gate = (cfg_throttle==0) | (lfsr[3:0] >= cfg_throttle).
  - lfsr is a Fibonacci LFSR with taps 16, 14, 13, 11, shifted every cycle in every state.
- Counters:
  - x increments on each issue; x wraps to 0 at W-1 and y increments.
  - At y=H-1 with x=W-1, y wraps and the frame counter increments.
  - sof = (x==0 & y==0). eol = (x==W-1).
  - The last frame is reached when cfg_num_frame != 0 and the frame counter + 1 == cfg_num_frame.
  - With cfg_num_frame=0, the frame counter wraps modulo 2^FRAME_W and the block runs until abort.
- Patterns (per channel c, value width BPC):
  - 0: solid = cfg_solid.
  - 1: H-ramp = x mod 2^BPC (all channels).
  - 2: V-ramp = y mod 2^BPC.
  - 3: checker = all-ones if x[3]^y[3], else 0.
  - 4: colour bars, with idx = x[7:5]. R = {BPC{~idx[1]}}, G = {BPC{~idx[2]}}, B = {BPC{~idx[0]}}. Channels c>=3 are 0.
  - 5: counter = linear pixel index y*W+x within the frame, zero-extended or truncated to CH*BPC.
  - 6: noise = lfsr replicated to CH*BPC.
  - 7: same as 0.
- Width rules:
  - Pixel index arithmetic is 2*DIM_W wide before truncation.
  - Ramps truncate, with no scaling.
  - W=1 gives eol on every beat. H=1 gives sof on every frame's first beat only.

Test Plan:
1. W=4, H=2, N=1, mode 5, throttle 0, full=0, pulse start -> 8 consecutive beats with data 0..7. sof on beat 0, eol on beats 3 and 7, done pulse the cycle after beat 7, busy then 0.
2. Same configuration as scenario 1 with fifo_full held high for 10 cycles after beat 2 -> wrreq is 0 from one cycle after full rises until one cycle after it falls. Data stays exactly 0..7 with no gaps in the sequence and no repeats.
3. Mode 4, CH=3, BPC=8, W=256, H=1 -> x=0 gives FFFFFF, x=32 gives FFFF00, x=64 gives 00FFFF, x=128 gives FF00FF, x=224 gives 000000.
4. W=2, H=2, N=3 -> 12 beats with sof on beats 0, 4 and 8, one done pulse. With N=0, beats continue past 12 until abort; after abort there is no done and busy=0.
5. cfg_width=0 with start -> no wrreq, done pulses 2 cycles after start, then IDLE.
6. Reset asserted mid-frame (mode 5) -> all outputs 0 asynchronously. The next start restarts at pixel 0 with sof=1.
